btn_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 30 +++
 rtl/btn_channel.sv | 125 ++++++++++++
 rtl/btn_conditioner.sv | 37 +++
 tb/tb_btn_conditioner.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding, timing defaults and button indices
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD_DELAY,
    HELD_REPEAT,
    DB_RELEASE
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  // One counter serves every timed state, so it is sized for the longest interval.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: 2-flop synchronizer, debounce/repeat FSM, shared counter
module btn_channel
  import btn_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int   CNT_W        = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, level_d, press_q, press_d, release_q, release_d;
  logic             p;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q   <= RELEASED_RAW;
      sync2_q   <= RELEASED_RAW;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    p       = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    // Saturate so a long hold without repeat never wraps into a false match.
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (p) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!p) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          level_d = 1'b1;
          press_d = 1'b1;
          state_d = HELD_DELAY;
          cnt_d   = '0;
        end
      end
      HELD_DELAY: begin
        if (!p) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end else if ((REPEAT_EN != 0) && (cnt_q == RD_LAST)) begin
          press_d = 1'b1;
          state_d = HELD_REPEAT;
          cnt_d   = '0;
        end
      end
      HELD_REPEAT: begin
        if (!p) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == RP_LAST) begin
          press_d = 1'b1;
          cnt_d   = '0;
        end
      end
      DB_RELEASE: begin
        // A bounce back to pressed resumes holding without a second press pulse.
        if (p) begin
          state_d = HELD_DELAY;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          level_d   = 1'b0;
          release_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - N_BTN independent debounced/auto-repeat button channels
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .btn_raw    (btn_raw[g]),
      .btn_level  (btn_level[g]),
      .btn_press  (btn_press[g]),
      .btn_release(btn_release[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - self-checking bench for btn_conditioner
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int N = 4;
  localparam int D = 4;
  localparam int R = 10;
  localparam int P = 3;

  logic         CLOCK_50 = 1'b0;
  logic         reset    = 1'b1;
  logic [N-1:0] btn_raw  = '1;
  logic [N-1:0] lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  btn_conditioner #(
    .N_BTN(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
    .REPEAT_EN(1), .REPEAT_DELAY(R), .REPEAT_PERIOD(P)
  ) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .btn_raw(btn_raw),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a)
  );

  btn_conditioner #(
    .N_BTN(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
    .REPEAT_EN(0), .REPEAT_DELAY(R), .REPEAT_PERIOD(P)
  ) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .btn_raw(btn_raw),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b)
  );

  // Reference model: index 0 mirrors dut_a (repeat on), index 1 dut_b (repeat off).
  logic [N-1:0] h1, h2, m_p;
  logic [N-1:0] e_lvl [2];
  logic [N-1:0] e_prs [2];
  logic [N-1:0] e_rel [2];
  int           m_run [2][N];
  int           m_age [2][N];

  task automatic model_reset();
    h1 = '1;
    h2 = '1;
    for (int k = 0; k < 2; k++) begin
      e_lvl[k] = '0;
      e_prs[k] = '0;
      e_rel[k] = '0;
      for (int i = 0; i < N; i++) begin
        m_run[k][i] = 0;
        m_age[k][i] = 0;
      end
    end
  endtask

  // Pressed state is accepted after D+1 consecutive pressed samples; repeats fire
  // R cycles after (re)entering the hold, then every P cycles.
  task automatic model_edge();
    m_p = ~h2;
    h2  = h1;
    h1  = btn_raw;
    for (int k = 0; k < 2; k++) begin
      e_prs[k] = '0;
      e_rel[k] = '0;
      for (int i = 0; i < N; i++) begin
        if (!e_lvl[k][i]) begin
          if (m_p[i]) begin
            m_run[k][i]++;
            if (m_run[k][i] == D + 1) begin
              e_lvl[k][i] = 1'b1;
              e_prs[k][i] = 1'b1;
              m_run[k][i] = 0;
              m_age[k][i] = 0;
            end
          end else begin
            m_run[k][i] = 0;
          end
        end else if (!m_p[i]) begin
          m_run[k][i]++;
          if (m_run[k][i] == D + 1) begin
            e_lvl[k][i] = 1'b0;
            e_rel[k][i] = 1'b1;
            m_run[k][i] = 0;
          end
        end else if (m_run[k][i] > 0) begin
          m_run[k][i] = 0;
          m_age[k][i] = 0;
        end else begin
          m_age[k][i]++;
          if (k == 0 && m_age[k][i] >= R && (m_age[k][i] - R) % P == 0)
            e_prs[k][i] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    if (reset) model_reset();
    else model_edge();
    @(negedge CLOCK_50);
  endtask

  function automatic logic [6*N-1:0] exp_vec();
    return {e_lvl[0], e_prs[0], e_rel[0], e_lvl[1], e_prs[1], e_rel[1]};
  endfunction

  function automatic logic [6*N-1:0] dut_vec();
    return {lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b};
  endfunction

  task automatic test_reset();
    model_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (dut_vec() !== '0) $display("FAIL reset_outputs c=%0d got %h exp 0", c, dut_vec());
      else n_pass++;
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL idle_model c=%0d got %h exp %h", c, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    btn_raw = 4'b1110;
    for (int c = 0; c < 13; c++) begin
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL clean_press_model c=%0d got %h exp %h", c, dut_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if (prs_a !== ((c == 6) ? 4'b0001 : 4'b0000) || lvl_a[BTN_UP] !== (c >= 6))
        $display("FAIL clean_press c=%0d press=%b level=%b exp press=%b level0=%b",
                 c, prs_a, lvl_a, (c == 6) ? 4'b0001 : 4'b0000, c >= 6);
      else n_pass++;
    end
    btn_raw = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL clean_release_model c=%0d got %h exp %h", c, dut_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if (rel_a !== ((c == 6) ? 4'b0001 : 4'b0000) || lvl_a[BTN_UP] !== (c < 6))
        $display("FAIL clean_release c=%0d release=%b level=%b exp release0=%b level0=%b",
                 c, rel_a, lvl_a, c == 6, c < 6);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [N-1:0] pat [4];
    pat = '{4'b1101, 4'b1101, 4'b1111, 4'b1101};
    for (int c = 0; c < 17; c++) begin
      btn_raw = (c < 4) ? pat[c] : 4'b1101;
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL bounce_model c=%0d got %h exp %h", c, dut_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if (prs_a[BTN_DOWN] !== (c == 9))
        $display("FAIL bounce_press c=%0d got %b exp %b", c, prs_a[BTN_DOWN], c == 9);
      else n_pass++;
    end
    btn_raw = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL bounce_release_model c=%0d got %h exp %h", c, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_hold_repeat();
    int  rep_cyc [7];
    logic want;
    rep_cyc = '{6, 16, 19, 22, 25, 28, 31};
    btn_raw = 4'b1011;
    for (int c = 0; c < 32; c++) begin
      step();
      want = 1'b0;
      for (int j = 0; j < 7; j++) if (rep_cyc[j] == c) want = 1'b1;
      n_checks++;
      if (prs_a[BTN_LEFT] !== want) $display("FAIL repeat_press c=%0d got %b exp %b", c, prs_a[BTN_LEFT], want);
      else n_pass++;
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL repeat_model c=%0d got %h exp %h", c, dut_vec(), exp_vec());
      else n_pass++;
    end
    btn_raw = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (rel_a[BTN_LEFT] !== (c == 6) || lvl_a[BTN_LEFT] !== (c < 6) || prs_a !== 4'b0000)
        $display("FAIL repeat_release c=%0d rel=%b lvl=%b prs=%b exp rel2=%b lvl2=%b prs=0000",
                 c, rel_a, lvl_a, prs_a, c == 6, c < 6);
      else n_pass++;
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL repeat_release_model c=%0d got %h exp %h", c, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_no_repeat();
    btn_raw = 4'b0111;
    for (int c = 0; c < 40; c++) begin
      step();
      n_checks++;
      if (prs_b !== ((c == 6) ? 4'b1000 : 4'b0000))
        $display("FAIL no_repeat_press c=%0d got %b exp %b", c, prs_b, (c == 6) ? 4'b1000 : 4'b0000);
      else n_pass++;
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL no_repeat_model c=%0d got %h exp %h", c, dut_vec(), exp_vec());
      else n_pass++;
    end
    btn_raw = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL no_repeat_release_model c=%0d got %h exp %h", c, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_multi_reset();
    btn_raw = 4'b0110;
    for (int c = 0; c < 9; c++) begin
      step();
      n_checks++;
      if (prs_a !== ((c == 6) ? 4'b1001 : 4'b0000) || prs_b !== ((c == 6) ? 4'b1001 : 4'b0000))
        $display("FAIL multi_press c=%0d a=%b b=%b exp %b", c, prs_a, prs_b, (c == 6) ? 4'b1001 : 4'b0000);
      else n_pass++;
    end
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== '0) $display("FAIL reset_immediate got %h exp 0", dut_vec());
    else n_pass++;
    step();
    step();
    n_checks++;
    if (dut_vec() !== '0) $display("FAIL reset_held got %h exp 0", dut_vec());
    else n_pass++;
    reset = 1'b0;
    for (int c = 0; c < 9; c++) begin
      step();
      n_checks++;
      if (prs_a !== ((c == 6) ? 4'b1001 : 4'b0000) || lvl_a !== ((c >= 6) ? 4'b1001 : 4'b0000))
        $display("FAIL repress_after_reset c=%0d press=%b level=%b exp press=%b", c, prs_a, lvl_a,
                 (c == 6) ? 4'b1001 : 4'b0000);
      else n_pass++;
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL repress_model c=%0d got %h exp %h", c, dut_vec(), exp_vec());
      else n_pass++;
    end
    btn_raw = 4'b1111;
    for (int c = 0; c < 10; c++) step();
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL multi_settle got %h exp %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_glitch();
    for (int c = 0; c < 21; c++) begin
      btn_raw = (c == 8 || c == 9) ? 4'b1111 : 4'b1110;
      step();
      n_checks++;
      if ((rel_a | rel_b) !== 4'b0000 || lvl_a[BTN_UP] !== (c >= 6) ||
          prs_a[BTN_UP] !== (c == 6) || prs_b[BTN_UP] !== (c == 6))
        $display("FAIL glitch c=%0d rel=%b/%b lvl=%b prs=%b/%b exp no release, lvl0=%b, prs0=%b",
                 c, rel_a, rel_b, lvl_a, prs_a, prs_b, c >= 6, c == 6);
      else n_pass++;
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL glitch_model c=%0d got %h exp %h", c, dut_vec(), exp_vec());
      else n_pass++;
    end
    btn_raw = 4'b1111;
    for (int c = 0; c < 10; c++) step();
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL glitch_settle got %h exp %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    int len;
    for (int s = 0; s < 150; s++) begin
      btn_raw = N'($urandom);
      len = $urandom_range(1, 25);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        model_reset();
        step();
        reset = 1'b0;
      end
      for (int c = 0; c < len; c++) begin
        step();
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL random_model seg=%0d c=%0d got %h exp %h", s, c, dut_vec(), exp_vec());
        else n_pass++;
        n_checks++;
        if (((prs_a & rel_a) | (prs_b & rel_b)) !== 4'b0000)
          $display("FAIL press_release_overlap seg=%0d got a=%b/%b b=%b/%b exp disjoint", s, prs_a, rel_a, prs_b, rel_b);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_repeat();
    test_no_repeat();
    test_multi_reset();
    test_glitch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
